rr_arbiter: RTL and testbench

//   Registered round-robin arbiter for NUM_REQ requesters sharing one resource.

---
 rtl/rr_arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 57 +++++
 rtl/rr_arbiter.sv | 99 +++++++++
 tb/tb_rr_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
//   Shared constants and helpers for the round-robin arbiter slice.
//
//   Contents:
//     NUM_REQ_DEFAULT  default number of requesters
//     PTR_W            width of the priority pointer for the default size
//     onehot_to_idx    converts a one-hot vector (up to 32 bits) to its index
//
//   Configuration macro used by this slice: RR_GRANT_HOLD_EN (see rr_arbiter).
// ---------------------------------------------------------------------------
package rr_arb_pkg;

   localparam int NUM_REQ_DEFAULT = 4;
   localparam int PTR_W           = $clog2(NUM_REQ_DEFAULT);

   // Index of the set bit in a one-hot vector. With exactly one bit set the
   // OR of all set-bit indices is that index; an all-zero vector yields 0, so
   // callers qualify the result with their own "any request" flag.
   function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selection. The request vector is rotated right
//   so that index ptr lands at bit 0. A fixed-priority lowest-bit search runs
//   on the rotated vector, and the result is rotated back to requester order.
//
//   Parameters:
//     NUM_REQ     number of requesters (2..32)
//
//   Ports:
//     req         in   NUM_REQ  request vector
//     ptr         in   PW       index of the highest-priority requester
//     grant_next  out  NUM_REQ  one-hot winner (zero when req is zero)
//     winner      out  PW       index of the winner (valid when any_req)
//     any_req     out  1        at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   localparam int PW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant_next,
   output logic [PW-1:0]      winner,
   output logic               any_req
);

   logic [2*NUM_REQ-1:0] req_doubled;
   logic [2*NUM_REQ-1:0] grant_doubled;
   logic [NUM_REQ-1:0]   req_rot;
   logic [NUM_REQ-1:0]   first_rot;
   int unsigned          first_idx;
   int unsigned          idx_sum;

   // Rotate, isolate the lowest set bit, rotate back. Doubling the vector
   // turns each rotation into a plain shift. x & -x keeps only the lowest
   // set bit, which is the highest-priority request after rotation. The
   // winner index is the rotated index plus ptr, wrapped modulo NUM_REQ.
   always_comb begin
      req_doubled   = {req, req} >> ptr;
      req_rot       = req_doubled[NUM_REQ-1:0];
      first_rot     = req_rot & (~req_rot + NUM_REQ'(1));
      grant_doubled = {first_rot, first_rot} << ptr;
      grant_next    = grant_doubled[2*NUM_REQ-1:NUM_REQ];
      any_req       = |req;

      first_idx = onehot_to_idx(32'(first_rot));
      idx_sum   = first_idx + 32'(ptr);
      if (idx_sum >= 32'(NUM_REQ)) begin
         idx_sum = idx_sum - 32'(NUM_REQ);
      end
      winner = PW'(idx_sum);
   end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Registered round-robin arbiter for NUM_REQ requesters sharing one
//   resource. req is sampled on each rising edge of clk, and the one-hot
//   grant for that sample appears one cycle later. After a grant to
//   requester k, requester k+1 (mod NUM_REQ) becomes the highest priority.
//   This rotation means no active requester can be starved.
//
//   Parameters:
//     NUM_REQ  number of requesters (2..32), default 4
//
//   Ports:
//     clk    in   1        rising-edge clock
//     rst_n  in   1        asynchronous active-low reset
//     req    in   NUM_REQ  request vector, bit i = requester i wants access
//     grant  out  NUM_REQ  registered one-hot grant, all-zero when idle
//
//   Configuration:
//     RR_GRANT_HOLD_EN  when defined, the current grantee keeps its grant
//                       while it continues requesting, and the pointer
//                       stays put. When undefined, the grant rotates every
//                       cycle among the active requesters.
// ---------------------------------------------------------------------------
module rr_arbiter
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   localparam int PW     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant
);

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_after_win;
   logic [NUM_REQ-1:0] grant_next;
   logic [PW-1:0]      winner;
   logic               any_req;

   rr_pick #(
      .NUM_REQ    (NUM_REQ)
   ) u_pick (
      .req        (req),
      .ptr        (ptr),
      .grant_next (grant_next),
      .winner     (winner),
      .any_req    (any_req)
   );

   // Priority moves to the requester just past the winner, wrapping to 0
   // after the last requester.
   always_comb begin
      if (winner == PW'(NUM_REQ - 1)) begin
         ptr_after_win = '0;
      end else begin
         ptr_after_win = winner + PW'(1);
      end
   end

`ifdef RR_GRANT_HOLD_EN
   logic holding;

   // The grantee is still requesting when its grant bit overlaps req.
   // The grant is one-hot, so at most one requester can match.
   assign holding = |(grant & req);
`endif

   // Grant and pointer registers. When no request is present, the grant
   // clears and the pointer keeps its position. In hold mode, the pointer
   // was already advanced past the grantee when the grant was first won.
   // Rotation therefore resumes from the correct place when the hold ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant <= '0;
         ptr   <= '0;
      end else begin
`ifdef RR_GRANT_HOLD_EN
         if (holding) begin
            grant <= grant;
         end else if (any_req) begin
            grant <= grant_next;
            ptr   <= ptr_after_win;
         end else begin
            grant <= '0;
         end
`else
         if (any_req) begin
            grant <= grant_next;
            ptr   <= ptr_after_win;
         end else begin
            grant <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed test of rr_arbiter with NUM_REQ=4. The expected values are
//   worked out by hand from the rotating-priority rule. The hold-mode
//   sequence is selected with RR_GRANT_HOLD_EN.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;

   int total;
   int bad;

   rr_arbiter #(
      .NUM_REQ (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .grant (grant)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its expected value and count the result.
   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
      end
   endtask

   // Drive req and wait one rising edge, then sample 1 time unit later.
   task automatic applyStimulus(input logic [3:0] value);
      req = value;
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and check that the grant clears at once.
   task automatic pulseReset(input string tag);
      rst_n = 1'b0;
      #1;
      checkOutput(tag, grant, 4'b0000);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      req   = 4'b0000;

      // Reset with all requests high: no grant, either before or at an edge.
      #2;
      rst_n = 1'b0;
      req   = 4'b1111;
      #1;
      checkOutput("reset_async", grant, 4'b0000);
      @(posedge clk);
      #1;
      checkOutput("reset_at_edge", grant, 4'b0000);
      rst_n = 1'b1;
      applyStimulus(4'b0000);
      checkOutput("idle_after_reset", grant, 4'b0000);

`ifdef RR_GRANT_HOLD_EN
      // Requester 0 wins first and then holds while it keeps requesting.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0011);
         checkOutput($sformatf("hold_0011_%0d", i), grant, 4'b0001);
      end
      applyStimulus(4'b0010);
      checkOutput("hold_release", grant, 4'b0010);
      applyStimulus(4'b0011);
      checkOutput("hold_req1", grant, 4'b0010);
      // Requester 1 drops; ptr=2, so search 2,3,0 finds requester 0.
      applyStimulus(4'b0001);
      checkOutput("hold_resume", grant, 4'b0001);
      applyStimulus(4'b0000);
      checkOutput("hold_idle", grant, 4'b0000);
`else
      // Single requester 3 is granted every cycle (ptr wraps to 0 each time).
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b1000);
         checkOutput($sformatf("single_1000_%0d", i), grant, 4'b1000);
      end

      // From a fresh reset, two requesters alternate.
      pulseReset("reset_pulse_a");
      applyStimulus(4'b0011);
      checkOutput("alt_0", grant, 4'b0001);
      applyStimulus(4'b0011);
      checkOutput("alt_1", grant, 4'b0010);
      applyStimulus(4'b0011);
      checkOutput("alt_2", grant, 4'b0001);
      applyStimulus(4'b0011);
      checkOutput("alt_3", grant, 4'b0010);

      // ptr=2: 3 wins, wraps to 0, then 1. After that, ptr=2.
      applyStimulus(4'b1011);
      checkOutput("mix_0", grant, 4'b1000);
      applyStimulus(4'b1011);
      checkOutput("mix_wrap", grant, 4'b0001);
      applyStimulus(4'b1011);
      checkOutput("mix_2", grant, 4'b0010);

      // Idle keeps ptr=2, so requester 2 beats requester 0.
      applyStimulus(4'b0000);
      checkOutput("idle_mid", grant, 4'b0000);
      applyStimulus(4'b0101);
      checkOutput("ptr_kept", grant, 4'b0100);

      // Reset mid-operation returns ptr to 0, so requester 1 beats requester 2.
      pulseReset("reset_pulse_b");
      applyStimulus(4'b0110);
      checkOutput("after_reset", grant, 4'b0010);

      // Grantee drops its request and the grant clears at the next edge.
      applyStimulus(4'b0000);
      checkOutput("drop_clear", grant, 4'b0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
